// File: rtl/csam_pkg.sv
// Shared types and constants for the carry-save multiplier scheduler.
package csam_pkg;

  localparam int DEF_XW      = 8;
  localparam int DEF_YW      = 5;
  localparam int DEF_PW      = DEF_XW + DEF_YW;
  localparam int MAX_MUL_LAT = 15;
  localparam int CNT_W       = $clog2(MAX_MUL_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csam_mul_sched_if.sv
// Requester, multiplier and response signals shared between the scheduler and its clients.
interface csam_mul_sched_if
  import csam_pkg::*;
#(
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW,
  parameter int NREQ = 4
);
  localparam int IW = idx_width(NREQ);
  localparam int PW = XW + YW;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ*YW-1:0] req_y;
  logic [XW-1:0]      mul_x;
  logic [YW-1:0]      mul_y;
  logic [PW-1:0]      mul_z;
  logic               resp_valid;
  logic               resp_ready;
  logic [IW-1:0]      resp_id;
  logic [PW-1:0]      resp_z;
  logic               busy;

  modport slave (
    input  req_valid, req_x, req_y, mul_z, resp_ready,
    output req_ready, mul_x, mul_y, resp_valid, resp_id, resp_z, busy
  );

  modport master (
    output req_valid, req_x, req_y, mul_z, resp_ready,
    input  req_ready, mul_x, mul_y, resp_valid, resp_id, resp_z, busy
  );

endinterface

// File: rtl/csam_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with wrap.
module rr_arbiter
  import csam_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]                req,
  input  logic [idx_width(NREQ)-1:0]     last_grant,
  input  logic                           en,
  output logic [NREQ-1:0]                grant,
  output logic [idx_width(NREQ)-1:0]     grant_idx
);
  localparam int IW = idx_width(NREQ);

  logic          found;
  logic [IW-1:0] idx;

  // Offset k=1 is the requester just after the previous winner, k=NREQ is the previous winner itself
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/csam_mul_sched.sv
// Shares one external carry-save array multiplier among NREQ requesters, giving the
// combinational product MUL_LAT cycles to settle before capturing it.
module csam_mul_sched
  import csam_pkg::*;
#(
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  csam_mul_sched_if.slave  bus
);
  localparam int IW = idx_width(NREQ);
  localparam int PW = XW + YW;

  state_t            state;
  state_t            nstate;
  logic [CNT_W-1:0]  cnt;
  logic [IW-1:0]     last_grant;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              arb_en;
  logic [XW-1:0]     mul_x_q;
  logic [YW-1:0]     mul_y_q;
  logic [PW-1:0]     resp_z_q;
  logic [IW-1:0]     resp_id_q;
  logic              resp_valid_q;

  // Arbitration only happens in IDLE, so req_ready is zero in WAIT and RESP
  assign arb_en = (state == IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .en         (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (|grant) nstate = WAIT;
      WAIT:    if (cnt == '0) nstate = RESP;
      RESP:    if (bus.resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Operands stay on the multiplier inputs from the grant until the next grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= IW'(NREQ - 1);
      cnt          <= '0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      resp_z_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: begin
          if (|grant) begin
            mul_x_q    <= bus.req_x[int'(grant_idx)*XW +: XW];
            mul_y_q    <= bus.req_y[int'(grant_idx)*YW +: YW];
            resp_id_q  <= grant_idx;
            last_grant <= grant_idx;
            cnt        <= CNT_W'(MUL_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            resp_z_q     <= bus.mul_z;
            resp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) resp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.mul_x      = mul_x_q;
  assign bus.mul_y      = mul_y_q;
  assign bus.resp_z     = resp_z_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_csam_mul_sched.sv
// Directed bench for csam_mul_sched with three instances at MUL_LAT 2, 4 and 1.
module tb_csam_mul_sched;
  localparam int XW   = 8;
  localparam int YW   = 5;
  localparam int NREQ = 4;
  localparam int PW   = XW + YW;

  logic clk = 1'b0;
  logic rst2, rst4, rst1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  csam_mul_sched_if #(.XW(XW), .YW(YW), .NREQ(NREQ)) bus2 ();
  csam_mul_sched_if #(.XW(XW), .YW(YW), .NREQ(NREQ)) bus4 ();
  csam_mul_sched_if #(.XW(XW), .YW(YW), .NREQ(NREQ)) bus1 ();

  // Behavioural CSAM for the MUL_LAT=2 and MUL_LAT=4 instances; bus1.mul_z is driven by hand
  assign bus2.mul_z = PW'(bus2.mul_x) * PW'(bus2.mul_y);
  assign bus4.mul_z = PW'(bus4.mul_x) * PW'(bus4.mul_y);

  csam_mul_sched #(.XW(XW), .YW(YW), .NREQ(NREQ), .MUL_LAT(2)) dut2 (.clk(clk), .reset(rst2), .bus(bus2));
  csam_mul_sched #(.XW(XW), .YW(YW), .NREQ(NREQ), .MUL_LAT(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));
  csam_mul_sched #(.XW(XW), .YW(YW), .NREQ(NREQ), .MUL_LAT(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
    bus2.req_valid = '0; bus2.req_x = '0; bus2.req_y = '0; bus2.resp_ready = 1'b0;
    bus4.req_valid = '0; bus4.req_x = '0; bus4.req_y = '0; bus4.resp_ready = 1'b0;
    bus1.req_valid = '0; bus1.req_x = '0; bus1.req_y = '0; bus1.resp_ready = 1'b0;
    bus1.mul_z = '0;
    tick();
    tick();
    total++;
    if ({bus2.req_ready, bus2.busy, bus2.resp_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {bus2.req_ready, bus2.busy, bus2.resp_valid});
    end
    total++;
    if ({bus2.mul_x, bus2.mul_y} !== 13'd0) begin
      bad++; $display("FAIL reset_mul got=%h want=0", {bus2.mul_x, bus2.mul_y});
    end
    total++;
    if ({bus2.resp_z, bus2.resp_id} !== 15'd0) begin
      bad++; $display("FAIL reset_resp got=%h want=0", {bus2.resp_z, bus2.resp_id});
    end
    rst2 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus2.req_x[2*XW +: XW] = 8'd255;
    bus2.req_y[2*YW +: YW] = 5'd31;
    bus2.req_valid  = 4'b0100;
    bus2.resp_ready = 1'b1;
    #1;
    total++;
    if (bus2.req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready got=%b want=0100", bus2.req_ready);
    end
    tick();
    bus2.req_valid = '0;
    #1;
    total++;
    if ({bus2.req_ready, bus2.busy, bus2.resp_valid, bus2.mul_x, bus2.mul_y} !== {4'b0000, 1'b1, 1'b0, 8'd255, 5'd31}) begin
      bad++; $display("FAIL single_wait got=%b/%b/%b/%0d/%0d want=0000/1/0/255/31",
                      bus2.req_ready, bus2.busy, bus2.resp_valid, bus2.mul_x, bus2.mul_y);
    end
    tick();
    total++;
    if (bus2.resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_early got=%b want=0", bus2.resp_valid);
    end
    tick();
    total++;
    if ({bus2.resp_valid, bus2.resp_z, bus2.resp_id} !== {1'b1, 13'd7905, 2'd2}) begin
      bad++; $display("FAIL single_resp got=%b/%0d/%0d want=1/7905/2", bus2.resp_valid, bus2.resp_z, bus2.resp_id);
    end
    tick();
    total++;
    if ({bus2.busy, bus2.resp_valid} !== 2'b00) begin
      bad++; $display("FAIL single_idle got=%b want=00", {bus2.busy, bus2.resp_valid});
    end
  endtask

  task automatic test_round_robin();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus2.req_x[i*XW +: XW] = XW'(i + 1);
      bus2.req_y[i*YW +: YW] = 5'd3;
    end
    bus2.resp_ready = 1'b1;
    bus2.req_valid  = 4'b1111;
    #1;
    for (int op = 0; op < 5; op++) begin
      int id;
      id = op % NREQ;
      total++;
      if (bus2.req_ready !== 4'(1 << id)) begin
        bad++; $display("FAIL rr_grant op=%0d got=%b want=%b", op, bus2.req_ready, 4'(1 << id));
      end
      tick();
      total++;
      if ({bus2.req_ready, bus2.resp_valid, bus2.mul_x} !== {4'b0000, 1'b0, 8'(id + 1)}) begin
        bad++; $display("FAIL rr_wait op=%0d got=%b/%b/%0d want=0000/0/%0d", op, bus2.req_ready, bus2.resp_valid, bus2.mul_x, id + 1);
      end
      tick();
      tick();
      total++;
      if ({bus2.resp_valid, bus2.resp_z, bus2.resp_id} !== {1'b1, 13'(3 * (id + 1)), 2'(id)}) begin
        bad++; $display("FAIL rr_resp op=%0d got=%b/%0d/%0d want=1/%0d/%0d", op, bus2.resp_valid, bus2.resp_z, bus2.resp_id, 3 * (id + 1), id);
      end
      tick();
    end
    bus2.req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    bus2.req_x[1*XW +: XW] = 8'd17;
    bus2.req_y[1*YW +: YW] = 5'd4;
    bus2.req_valid  = 4'b0010;
    bus2.resp_ready = 1'b0;
    #1;
    total++;
    if (bus2.req_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_grant got=%b want=0010", bus2.req_ready);
    end
    tick();
    bus2.req_valid = 4'b1111;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus2.resp_valid, bus2.resp_z, bus2.resp_id, bus2.req_ready} !== {1'b1, 13'd68, 2'd1, 4'b0000}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%0d/%b want=1/68/1/0000",
                        i, bus2.resp_valid, bus2.resp_z, bus2.resp_id, bus2.req_ready);
      end
      tick();
    end
    bus2.resp_ready = 1'b1;
    tick();
    total++;
    if ({bus2.resp_valid, bus2.busy, bus2.req_ready} !== {1'b0, 1'b0, 4'b0100}) begin
      bad++; $display("FAIL bp_release got=%b/%b/%b want=0/0/0100", bus2.resp_valid, bus2.busy, bus2.req_ready);
    end
    bus2.req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus4.req_x[2*XW +: XW] = 8'd9;
    bus4.req_y[2*YW +: YW] = 5'd9;
    bus4.req_valid  = 4'b0100;
    bus4.resp_ready = 1'b1;
    #1;
    total++;
    if (bus4.req_ready !== 4'b0100) begin
      bad++; $display("FAIL rst_grant got=%b want=0100", bus4.req_ready);
    end
    tick();
    bus4.req_valid = '0;
    tick();
    rst4 = 1'b1;
    #1;
    total++;
    if ({bus4.busy, bus4.resp_valid, bus4.mul_x, bus4.mul_y, bus4.resp_id, bus4.resp_z} !== 30'd0) begin
      bad++; $display("FAIL rst_async got=%b/%b/%0d/%0d/%0d/%0d want=all zero",
                      bus4.busy, bus4.resp_valid, bus4.mul_x, bus4.mul_y, bus4.resp_id, bus4.resp_z);
    end
    tick();
    rst4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({bus4.resp_valid, bus4.busy} !== 2'b00) begin
        bad++; $display("FAIL rst_no_resp cyc=%0d got=%b want=00", i, {bus4.resp_valid, bus4.busy});
      end
    end
    bus4.req_x[0*XW +: XW] = 8'd5;
    bus4.req_y[0*YW +: YW] = 5'd6;
    bus4.req_valid = 4'b0101;
    #1;
    total++;
    if (bus4.req_ready !== 4'b0001) begin
      bad++; $display("FAIL rst_priority got=%b want=0001", bus4.req_ready);
    end
    tick();
    bus4.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus4.resp_valid !== 1'b0) begin
        bad++; $display("FAIL lat4_early cyc=%0d got=%b want=0", i, bus4.resp_valid);
      end
    end
    tick();
    total++;
    if ({bus4.resp_valid, bus4.resp_z, bus4.resp_id} !== {1'b1, 13'd30, 2'd0}) begin
      bad++; $display("FAIL lat4_resp got=%b/%0d/%0d want=1/30/0", bus4.resp_valid, bus4.resp_z, bus4.resp_id);
    end
    tick();
  endtask

  task automatic test_mul_lat1();
    int ids[2] = '{3, 1};
    int xs[2]  = '{0, 200};
    int ys[2]  = '{31, 7};
    int zs[2]  = '{0, 1400};
    for (int n = 0; n < 2; n++) begin
      bus1.req_x[ids[n]*XW +: XW] = XW'(xs[n]);
      bus1.req_y[ids[n]*YW +: YW] = YW'(ys[n]);
      bus1.req_valid  = 4'(1 << ids[n]);
      bus1.resp_ready = 1'b0;
      bus1.mul_z      = 13'h1555;
      #1;
      total++;
      if (bus1.req_ready !== 4'(1 << ids[n])) begin
        bad++; $display("FAIL l1_grant n=%0d got=%b want=%b", n, bus1.req_ready, 4'(1 << ids[n]));
      end
      tick();
      bus1.req_valid = '0;
      bus1.mul_z     = PW'(zs[n]);
      tick();
      bus1.mul_z = 13'h0aaa;
      total++;
      if ({bus1.resp_valid, bus1.resp_z, bus1.resp_id} !== {1'b1, 13'(zs[n]), 2'(ids[n])}) begin
        bad++; $display("FAIL l1_resp n=%0d got=%b/%0d/%0d want=1/%0d/%0d", n, bus1.resp_valid, bus1.resp_z, bus1.resp_id, zs[n], ids[n]);
      end
      tick();
      total++;
      if ({bus1.resp_valid, bus1.resp_z} !== {1'b1, 13'(zs[n])}) begin
        bad++; $display("FAIL l1_hold n=%0d got=%b/%0d want=1/%0d", n, bus1.resp_valid, bus1.resp_z, zs[n]);
      end
      bus1.resp_ready = 1'b1;
      tick();
      total++;
      if ({bus1.busy, bus1.resp_valid} !== 2'b00) begin
        bad++; $display("FAIL l1_idle n=%0d got=%b want=00", n, {bus1.busy, bus1.resp_valid});
      end
    end
    bus1.resp_ready = 1'b0;
  endtask

  task automatic test_withdrawal();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    bus2.req_x[0*XW +: XW] = 8'd2;
    bus2.req_y[0*YW +: YW] = 5'd2;
    bus2.req_x[3*XW +: XW] = 8'd11;
    bus2.req_y[3*YW +: YW] = 5'd3;
    bus2.req_valid  = 4'b0001;
    bus2.resp_ready = 1'b0;
    #1;
    total++;
    if (bus2.req_ready !== 4'b0001) begin
      bad++; $display("FAIL wd_first got=%b want=0001", bus2.req_ready);
    end
    tick();
    bus2.req_valid = '0;
    tick();
    tick();
    total++;
    if ({bus2.resp_valid, bus2.resp_z} !== {1'b1, 13'd4}) begin
      bad++; $display("FAIL wd_first_resp got=%b/%0d want=1/4", bus2.resp_valid, bus2.resp_z);
    end
    bus2.req_valid = 4'b1010;
    #1;
    total++;
    if (bus2.req_ready !== 4'b0000) begin
      bad++; $display("FAIL wd_resp_ready got=%b want=0000", bus2.req_ready);
    end
    tick();
    bus2.req_valid  = 4'b1000;
    bus2.resp_ready = 1'b1;
    #1;
    total++;
    if (bus2.req_ready !== 4'b0000) begin
      bad++; $display("FAIL wd_resp_ready2 got=%b want=0000", bus2.req_ready);
    end
    tick();
    total++;
    if (bus2.req_ready !== 4'b1000) begin
      bad++; $display("FAIL wd_grant got=%b want=1000", bus2.req_ready);
    end
    tick();
    bus2.req_valid = '0;
    tick();
    tick();
    total++;
    if ({bus2.resp_valid, bus2.resp_z, bus2.resp_id} !== {1'b1, 13'd33, 2'd3}) begin
      bad++; $display("FAIL wd_resp got=%b/%0d/%0d want=1/33/3", bus2.resp_valid, bus2.resp_z, bus2.resp_id);
    end
    tick();
    total++;
    if (bus2.busy !== 1'b0) begin
      bad++; $display("FAIL wd_idle got=%b want=0", bus2.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_wait();
    test_mul_lat1();
    test_withdrawal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
